// File: rtl/sigma_delta_cic_decimator_pkg.sv
// Shared constants and elaboration-time helpers for the sigma-delta CIC decimator.
package sigma_delta_cic_decimator_pkg;

    // A 1-bit stream symbol expands to a 2-bit signed value of +1 or -1.
    localparam logic [1:0] SD_PLUS_ONE  = 2'b01;
    localparam logic [1:0] SD_MINUS_ONE = 2'b11;

    function automatic int cic_eff_in(input int in_width);
        return (in_width == 1) ? 2 : in_width;
    endfunction

    function automatic int cic_width(input int in_width, input int order, input int dec_log2);
        return cic_eff_in(in_width) + order * dec_log2;
    endfunction

    function automatic bit cic_params_legal(input int in_width, input int order,
                                            input int dec_log2, input int out_width);
        return (in_width >= 1) && (order >= 1) && (order <= 5) &&
               (dec_log2 >= 1) && (dec_log2 <= 10) && (out_width >= 1);
    endfunction

endpackage

// File: rtl/sigma_delta_cic_decimator_comb_stage.sv
// One CIC comb stage: strobe-enabled delay register and the exact modulo-2^W difference.
module cic_comb_stage #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         strobe,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            dly <= '0;
        end else if (strobe) begin
            dly <= din;
        end
    end

    always_comb dout = din - dly;

endmodule

// File: rtl/sigma_delta_cic_decimator.sv
// CIC decimator turning a low-width sigma-delta stream into signed PCM at 1/2^DEC_LOG2 rate.
module sigma_delta_cic_decimator
    import sigma_delta_cic_decimator_pkg::*;
#(
    parameter int IN_WIDTH  = 1,
    parameter int ORDER     = 2,
    parameter int DEC_LOG2  = 6,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [IN_WIDTH-1:0]  in,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 outValid
);

    localparam int EFF_IN = cic_eff_in(IN_WIDTH);
    localparam int W      = cic_width(IN_WIDTH, ORDER, DEC_LOG2);

    if (!cic_params_legal(IN_WIDTH, ORDER, DEC_LOG2, OUT_WIDTH)) begin : g_param_check
        $error("sigma_delta_cic_decimator: parameter out of legal range");
    end

    logic [EFF_IN-1:0]    x_eff;
    logic [W-1:0]         x_ext;
    logic [DEC_LOG2-1:0]  cnt;
    logic                 strobe;
    logic [W-1:0]         integ_last;
    logic [W-1:0]         comb_last;
    logic [OUT_WIDTH-1:0] scaled;

    if (IN_WIDTH == 1) begin : g_map_bit
        always_comb x_eff = in[0] ? SD_PLUS_ONE : SD_MINUS_ONE;
    end else begin : g_map_word
        always_comb x_eff = in;
    end

    always_comb x_ext = {{(W-EFF_IN){x_eff[EFF_IN-1]}}, x_eff};

    // Integrator chain wraps modulo 2^W; each stage accumulates the previous stage's old value.
    for (genvar k = 0; k < ORDER; k++) begin : g_integ
        logic [W-1:0] acc;
        logic [W-1:0] feed;
        if (k == 0) begin : g_src
            always_comb feed = x_ext;
        end else begin : g_src
            always_comb feed = g_integ[k-1].acc;
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                acc <= '0;
            end else if (en) begin
                acc <= acc + feed;
            end
        end
    end

    always_comb integ_last = g_integ[ORDER-1].acc;

    for (genvar k = 0; k < ORDER; k++) begin : g_comb
        logic [W-1:0] cin;
        logic [W-1:0] cout;
        if (k == 0) begin : g_src
            always_comb cin = integ_last;
        end else begin : g_src
            always_comb cin = g_comb[k-1].cout;
        end
        cic_comb_stage #(.W(W)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .strobe (strobe),
            .din    (cin),
            .dout   (cout)
        );
    end

    always_comb comb_last = g_comb[ORDER-1].cout;

    if (OUT_WIDTH <= W) begin : g_trunc
        always_comb scaled = comb_last[W-1 -: OUT_WIDTH];
        if (OUT_WIDTH < W) begin : g_drop
            logic unused_lsbs;
            always_comb unused_lsbs = ^comb_last[W-OUT_WIDTH-1:0];
        end
    end else begin : g_pad
        always_comb scaled = {comb_last, {(OUT_WIDTH-W){1'b0}}};
    end

    always_comb strobe = en && (cnt == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            out      <= '0;
            outValid <= 1'b0;
        end else begin
            outValid <= strobe;
            if (en) begin
                cnt <= cnt + DEC_LOG2'(1);
            end
            if (strobe) begin
                out <= scaled;
            end
        end
    end

endmodule

// File: tb/tb_sigma_delta_cic_decimator.sv
// Directed bench: default 1-bit CIC2/R=64 instance plus a 4-bit CIC3/R=16 instance.
module tb_sigma_delta_cic_decimator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_a = 1'b0;
    logic [0:0]  in_a = 1'b0;
    logic [15:0] out_a;
    logic        valid_a;
    logic        en_b = 1'b0;
    logic [3:0]  in_b = 4'd0;
    logic [15:0] out_b;
    logic        valid_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] vals_a[$];
    int          times_a[$];
    logic [15:0] vals_b[$];
    int          cyc = 0;
    int          bad_valid = 0;
    logic        en_seen_a = 1'b0;

    sigma_delta_cic_decimator dut_a (
        .clk      (clk),
        .rst      (rst),
        .en       (en_a),
        .in       (in_a),
        .out      (out_a),
        .outValid (valid_a)
    );

    sigma_delta_cic_decimator #(
        .IN_WIDTH  (4),
        .ORDER     (3),
        .DEC_LOG2  (4),
        .OUT_WIDTH (16)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .en       (en_b),
        .in       (in_b),
        .out      (out_b),
        .outValid (valid_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) en_seen_a <= en_a;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (valid_a) begin
            vals_a.push_back(out_a);
            times_a.push_back(cyc);
            if (!en_seen_a) bad_valid <= bad_valid + 1;
        end
        if (valid_b) vals_b.push_back(out_b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qat(input logic [15:0] q[$], input int i);
        if (i < q.size()) return {16'h0, q[i]};
        return 'x;
    endfunction

    function automatic logic [31:0] tdiff(input int q[$], input int i);
        if (i < q.size() && i > 0) return q[i] - q[i-1];
        return 'x;
    endfunction

    task automatic clear_logs();
        vals_a.delete();
        times_a.delete();
        vals_b.delete();
        bad_valid = 0;
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en_a = 1'b0;
            en_b = 1'b0;
        end
    endtask

    // mode: 0 const 0, 1 const 1, 2 alternating 1/0, 3 first-order modulator of sdm_x
    task automatic drive_a(input int nen, input int gap, input int mode, input int sdm_x);
        int   acc;
        logic b;
        acc = 0;
        for (int i = 0; i < nen; i++) begin
            case (mode)
                0: b = 1'b0;
                1: b = 1'b1;
                2: b = (i % 2 == 0);
                default: begin
                    b   = (acc >= 0);
                    acc = acc + sdm_x - (b ? 32768 : -32768);
                end
            endcase
            @(negedge clk);
            en_a = 1'b1;
            in_a = b;
            for (int g = 1; g < gap; g++) begin
                @(negedge clk);
                en_a = 1'b0;
            end
        end
        @(negedge clk);
        en_a = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        logic d_ok;
        int   d;

        reset_all();
        check("reset_out", {16'h0, out_a}, 32'h0);
        check("reset_valid", {31'h0, valid_a}, 32'h0);

        // Constant 1: transients 1953<<2 and 4095<<2, then full scale 0x4000.
        drive_a(640, 1, 1, 0);
        idle(3);
        check("ones_count", vals_a.size(), 10);
        check("ones_v0", qat(vals_a, 0), 32'h1E84);
        check("ones_v1", qat(vals_a, 1), 32'h3FFC);
        for (int i = 2; i < 10; i++) check($sformatf("ones_v%0d", i), qat(vals_a, i), 32'h4000);
        for (int i = 1; i < 10; i++) check($sformatf("ones_gap%0d", i), tdiff(times_a, i), 64);
        check("ones_valid_en", bad_valid, 0);

        reset_all();
        drive_a(256, 1, 0, 0);
        idle(3);
        check("zeros_v0", qat(vals_a, 0), 32'hE17C);
        check("zeros_v1", qat(vals_a, 1), 32'hC004);
        check("zeros_v2", qat(vals_a, 2), 32'hC000);
        check("zeros_v3", qat(vals_a, 3), 32'hC000);

        reset_all();
        drive_a(256, 1, 2, 0);
        idle(3);
        check("alt_v0", qat(vals_a, 0), 32'h007C);
        check("alt_v1", qat(vals_a, 1), 32'h0004);
        check("alt_v2", qat(vals_a, 2), 32'h0000);
        check("alt_v3", qat(vals_a, 3), 32'h0000);

        reset_all();
        drive_a(256, 1, 3, 0);
        idle(3);
        for (int i = 2; i < 4; i++) begin
            d    = int'($signed(qat(vals_a, i) & 32'hFFFF)) ;
            d    = (d >= 32768) ? d - 65536 : d;
            d_ok = (vals_a.size() > i) && (d >= -2) && (d <= 2);
            check($sformatf("sdm_zero_v%0d", i), {31'h0, d_ok}, 32'h1);
        end

        reset_all();
        drive_a(256, 1, 3, 16384);
        idle(3);
        for (int i = 2; i < 4; i++) begin
            d    = int'(qat(vals_a, i) & 32'hFFFF) - 32'sh2000;
            d_ok = (vals_a.size() > i) && (d >= -2) && (d <= 2);
            check($sformatf("sdm_half_v%0d", i), {31'h0, d_ok}, 32'h1);
        end

        // en asserted one clock in three: same data, 192-clock spacing.
        reset_all();
        drive_a(640, 3, 1, 0);
        idle(3);
        check("gated_count", vals_a.size(), 10);
        check("gated_v0", qat(vals_a, 0), 32'h1E84);
        check("gated_v1", qat(vals_a, 1), 32'h3FFC);
        for (int i = 2; i < 10; i++) check($sformatf("gated_v%0d", i), qat(vals_a, i), 32'h4000);
        for (int i = 1; i < 10; i++) check($sformatf("gated_gap%0d", i), tdiff(times_a, i), 192);
        check("gated_valid_en", bad_valid, 0);

        // Reset with en high at cnt=37, then restart from a fresh frame.
        reset_all();
        drive_a(101, 1, 1, 0);
        @(negedge clk);
        rst = 1'b1; en_a = 1'b1; in_a = 1'b1;
        @(negedge clk);
        rst = 1'b0; en_a = 1'b0;
        check("midrst_out", {16'h0, out_a}, 32'h0);
        check("midrst_valid", {31'h0, valid_a}, 32'h0);
        clear_logs();
        n = 0;
        do begin
            @(negedge clk);
            en_a = 1'b1; in_a = 1'b1;
            n++;
            @(posedge clk);
            #1;
        end while (!valid_a && n < 200);
        check("midrst_first_strobe", n, 64);
        drive_a(128, 1, 1, 0);
        idle(3);
        check("midrst_v0", qat(vals_a, 0), 32'h1E84);
        check("midrst_v1", qat(vals_a, 1), 32'h3FFC);
        check("midrst_v2", qat(vals_a, 2), 32'h4000);

        // 4-bit stream, CIC3, R=16, constant 3: first output 15*14*13/2, then 3*4096.
        reset_all();
        for (int i = 0; i < 112; i++) begin
            @(negedge clk);
            en_b = 1'b1;
            in_b = 4'd3;
        end
        idle(3);
        check("mb_count", vals_b.size(), 7);
        check("mb_v0", qat(vals_b, 0), 32'h0555);
        for (int i = 3; i < 7; i++) check($sformatf("mb_v%0d", i), qat(vals_b, i), 32'h3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
